// File: rtl/score_pkg.sv
// Shared definitions for the score-keeping blocks.
//   grade_t          : 2-bit per-lane judgement grade
//   GRADE_*          : grade encodings (11 is reserved and scores as a miss)
//   DEF_*            : default saturation limits and base points
package score_pkg;

    typedef logic [1:0] grade_t;

    localparam grade_t GRADE_MISS    = 2'b00;
    localparam grade_t GRADE_GOOD    = 2'b01;
    localparam grade_t GRADE_PERFECT = 2'b10;
    localparam grade_t GRADE_RSVD    = 2'b11;

    localparam int DEF_SCORE_MAX   = 9999;
    localparam int DEF_MULT_MAX    = 99;
    localparam int DEF_PTS_PERFECT = 2;
    localparam int DEF_PTS_GOOD    = 1;

endpackage

// File: rtl/lane_grade_counter.sv
// Combinational popcount of valid lanes per grade plus the base-points sum.
// Ports:
//   ev_valid [LANES]   : per-lane judgement strobe (invalid lanes are ignored)
//   ev_grade [2*LANES] : per-lane grade, lane i in bits [2i+1:2i]
//   n_perf/n_good/n_miss [CNT_W] : lane counts per grade (reserved counts as miss)
//   base [BASE_W]      : n_perf*PTS_PERFECT + n_good*PTS_GOOD
module lane_grade_counter
    import score_pkg::*;
#(
    parameter int LANES       = 8,
    parameter int PTS_PERFECT = DEF_PTS_PERFECT,
    parameter int PTS_GOOD    = DEF_PTS_GOOD,
    parameter int CNT_W       = $clog2(LANES) + 1,
    parameter int BASE_W      = 5
) (
    input  logic [LANES-1:0]   ev_valid,
    input  logic [2*LANES-1:0] ev_grade,
    output logic [CNT_W-1:0]   n_perf,
    output logic [CNT_W-1:0]   n_good,
    output logic [CNT_W-1:0]   n_miss,
    output logic [BASE_W-1:0]  base
);

    always_comb begin
        n_perf = '0;
        n_good = '0;
        n_miss = '0;
        for (int i = 0; i < LANES; i++) begin
            if (ev_valid[i]) begin
                case (grade_t'(ev_grade[2*i +: 2]))
                    GRADE_PERFECT: n_perf = n_perf + CNT_W'(1);
                    GRADE_GOOD:    n_good = n_good + CNT_W'(1);
                    default:       n_miss = n_miss + CNT_W'(1);
                endcase
            end
        end
        base = BASE_W'(n_perf) * BASE_W'(PTS_PERFECT)
             + BASE_W'(n_good) * BASE_W'(PTS_GOOD);
    end

endmodule

// File: rtl/score_keeper_multi.sv
// Multi-lane score keeper: two-stage pipeline turning per-lane judgement
// events into a saturating score, streak-driven multiplier, combo and best
// combo for the 7-segment / HUD displays.
// Ports:
//   clk, rst_n      : clock, synchronous active-low reset
//   freeze          : pause; holds all state and drops events
//   ev_valid[LANES] : per-lane event strobe
//   ev_grade[2*LANES]: per-lane grade (00 MISS, 01 GOOD, 10 PERFECT, 11 MISS)
//   score, multiplier, combo, max_combo : display values
//   update          : one-cycle pulse after each state update
module score_keeper_multi
    import score_pkg::*;
#(
    parameter int LANES       = 8,
    parameter int SCORE_W     = 16,
    parameter int SCORE_MAX   = DEF_SCORE_MAX,
    parameter int MULT_W      = 7,
    parameter int MULT_MAX    = DEF_MULT_MAX,
    parameter int COMBO_W     = 10,
    parameter int PTS_PERFECT = DEF_PTS_PERFECT,
    parameter int PTS_GOOD    = DEF_PTS_GOOD
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 freeze,
    input  logic [LANES-1:0]     ev_valid,
    input  logic [2*LANES-1:0]   ev_grade,
    output logic [SCORE_W-1:0]   score,
    output logic [MULT_W-1:0]    multiplier,
    output logic [COMBO_W-1:0]   combo,
    output logic [COMBO_W-1:0]   max_combo,
    output logic                 update
);

    localparam int CNT_W     = $clog2(LANES) + 1;
    localparam int PTS_HI    = (PTS_PERFECT > PTS_GOOD) ? PTS_PERFECT : PTS_GOOD;
    localparam int BASE_W    = $clog2(LANES * PTS_HI + 1);
    // Wide enough that score + base*multiplier never wraps before saturation.
    localparam int WIDE_W    = SCORE_W + MULT_W + 4;
    localparam int COMBO_MAX = (1 << COMBO_W) - 1;

    function automatic logic [SCORE_W-1:0] sat_score(input logic [WIDE_W-1:0] v);
        return (v > WIDE_W'(SCORE_MAX)) ? SCORE_W'(SCORE_MAX) : v[SCORE_W-1:0];
    endfunction

    function automatic logic [COMBO_W-1:0] sat_combo(input logic [WIDE_W-1:0] v);
        return (v > WIDE_W'(COMBO_MAX)) ? COMBO_W'(COMBO_MAX) : v[COMBO_W-1:0];
    endfunction

    function automatic logic [MULT_W-1:0] sat_streak(input logic [WIDE_W-1:0] v);
        return (v > WIDE_W'(MULT_MAX)) ? MULT_W'(MULT_MAX) : v[MULT_W-1:0];
    endfunction

    // ---- stage 0 -> 1 : per-lane grade counting and capture ----
    logic [CNT_W-1:0]  n_perf_p0, n_good_p0, n_miss_p0;
    logic [BASE_W-1:0] base_p0;

    logic [CNT_W-1:0]  n_perf_p1, n_good_p1, n_miss_p1;
    logic [BASE_W-1:0] base_p1;
    logic              vld_p1;

    lane_grade_counter #(
        .LANES       (LANES),
        .PTS_PERFECT (PTS_PERFECT),
        .PTS_GOOD    (PTS_GOOD),
        .CNT_W       (CNT_W),
        .BASE_W      (BASE_W)
    ) u_counter (
        .ev_valid (ev_valid),
        .ev_grade (ev_grade),
        .n_perf   (n_perf_p0),
        .n_good   (n_good_p0),
        .n_miss   (n_miss_p0),
        .base     (base_p0)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_p1    <= 1'b0;
            n_perf_p1 <= '0;
            n_good_p1 <= '0;
            n_miss_p1 <= '0;
            base_p1   <= '0;
        end else if (freeze) begin
            // Clearing the valid also discards an event already captured.
            vld_p1 <= 1'b0;
        end else begin
            vld_p1    <= |ev_valid;
            n_perf_p1 <= n_perf_p0;
            n_good_p1 <= n_good_p0;
            n_miss_p1 <= n_miss_p0;
            base_p1   <= base_p0;
        end
    end

    // ---- stage 1 -> 2 : score / multiplier / combo update ----
    logic [MULT_W-1:0]  streak;
    logic [WIDE_W-1:0]  hits_w, score_sum, combo_sum, streak_sum;
    logic [SCORE_W-1:0] score_nx;
    logic [COMBO_W-1:0] combo_sat, max_nx;
    logic               step;

    always_comb begin
        hits_w     = WIDE_W'(n_perf_p1) + WIDE_W'(n_good_p1);
        // Points use the multiplier held before this update.
        score_sum  = WIDE_W'(score) + WIDE_W'(base_p1) * WIDE_W'(multiplier);
        score_nx   = sat_score(score_sum);
        combo_sum  = WIDE_W'(combo) + hits_w;
        combo_sat  = sat_combo(combo_sum);
        // Same value serves the miss case: hits still count before the clear.
        max_nx     = (combo_sat > max_combo) ? combo_sat : max_combo;
        streak_sum = WIDE_W'(streak) + hits_w;
        step       = (streak_sum >= WIDE_W'(multiplier))
                  && (multiplier < MULT_W'(MULT_MAX));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            score      <= '0;
            multiplier <= MULT_W'(1);
            combo      <= '0;
            max_combo  <= '0;
            streak     <= '0;
            update     <= 1'b0;
        end else begin
            update <= 1'b0;
            if (vld_p1 && !freeze) begin
                update    <= 1'b1;
                score     <= score_nx;
                max_combo <= max_nx;
                if (n_miss_p1 != '0) begin
                    multiplier <= MULT_W'(1);
                    streak     <= '0;
                    combo      <= '0;
                end else begin
                    combo <= combo_sat;
                    if (step) begin
                        multiplier <= multiplier + MULT_W'(1);
                        streak     <= MULT_W'(streak_sum - WIDE_W'(multiplier));
                    end else begin
                        streak <= sat_streak(streak_sum);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_score_keeper_multi.sv
// Testbench for score_keeper_multi: table-driven vectors and a reference
// model feed an expectation queue that is checked two cycles after each event.
module tb_score_keeper_multi;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        freeze;
    logic [7:0]  ev_valid;
    logic [15:0] ev_grade;
    logic [15:0] score;
    logic [6:0]  multiplier;
    logic [9:0]  combo;
    logic [9:0]  max_combo;
    logic        update;

    score_keeper_multi dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .freeze     (freeze),
        .ev_valid   (ev_valid),
        .ev_grade   (ev_grade),
        .score      (score),
        .multiplier (multiplier),
        .combo      (combo),
        .max_combo  (max_combo),
        .update     (update)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int due;
        int score;
        int mult;
        int combo;
        int maxc;
    } exp_t;

    typedef struct {
        logic [7:0]  v;
        logic [15:0] g;
        int s;
        int m;
        int c;
        int mc;
    } vec_t;

    exp_t q[$];
    int checks = 0;
    int failures = 0;

    // reference model state
    int m_score, m_mult, m_streak, m_combo, m_max;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_score = 0; m_mult = 1; m_streak = 0; m_combo = 0; m_max = 0;
    endtask

    task automatic model_step(input logic [7:0] v, input logic [15:0] g);
        int np, ng, nm, hits, s, nc;
        np = 0; ng = 0; nm = 0;
        for (int i = 0; i < 8; i++) begin
            if (v[i]) begin
                case (g[2*i +: 2])
                    2'b10:   np++;
                    2'b01:   ng++;
                    default: nm++;
                endcase
            end
        end
        if (np + ng + nm == 0) return;
        hits = np + ng;
        m_score = m_score + (2 * np + ng) * m_mult;
        if (m_score > 9999) m_score = 9999;
        nc = m_combo + hits;
        if (nc > 1023) nc = 1023;
        if (nc > m_max) m_max = nc;
        if (nm > 0) begin
            m_mult = 1; m_streak = 0; m_combo = 0;
        end else begin
            m_combo = nc;
            s = m_streak + hits;
            if (s >= m_mult && m_mult < 99) begin
                m_streak = s - m_mult;
                m_mult = m_mult + 1;
            end else begin
                m_streak = (s > 99) ? 99 : s;
            end
        end
    endtask

    task automatic tick(input logic [7:0] v, input logic [15:0] g, input logic f);
        @(posedge clk);
        #1;
        ev_valid = v;
        ev_grade = g;
        freeze   = f;
    endtask

    task automatic idle(input int n);
        repeat (n) tick(8'h00, 16'h0000, 1'b0);
    endtask

    task automatic send(input logic [7:0] v, input logic [15:0] g);
        tick(v, g, 1'b0);
        model_step(v, g);
        if (v != 8'h00)
            q.push_back('{due: cyc + 2, score: m_score, mult: m_mult, combo: m_combo, maxc: m_max});
    endtask

    task automatic send_exp(input vec_t t);
        tick(t.v, t.g, 1'b0);
        model_step(t.v, t.g);
        q.push_back('{due: cyc + 2, score: t.s, mult: t.m, combo: t.c, maxc: t.mc});
    endtask

    task automatic check_now(input string tag, input int s, input int m, input int c,
                             input int mc, input int u);
        @(negedge clk);
        chk({tag, "_score"}, int'(score), s);
        chk({tag, "_mult"}, int'(multiplier), m);
        chk({tag, "_combo"}, int'(combo), c);
        chk({tag, "_maxcombo"}, int'(max_combo), mc);
        chk({tag, "_update"}, int'(update), u);
    endtask

    task automatic do_reset();
        idle(3);
        @(posedge clk);
        #1;
        rst_n = 1'b0; ev_valid = 8'hFF; ev_grade = 16'hAAAA; freeze = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1; ev_valid = 8'h00; ev_grade = 16'h0000;
        model_reset();
    endtask

    // scoreboard: compare the oldest expectation when its cycle arrives
    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0 && q[0].due == cyc) begin
            e = q.pop_front();
            chk("q_score", int'(score), e.score);
            chk("q_mult", int'(multiplier), e.mult);
            chk("q_combo", int'(combo), e.combo);
            chk("q_maxcombo", int'(max_combo), e.maxc);
            chk("q_update", int'(update), 1);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    vec_t ramp[6];
    vec_t mix[10];
    vec_t sat[7];

    initial begin
        logic [15:0] r;
        logic [15:0] gg;

        ramp[0] = '{8'h01, 16'hFFFE,  2, 2, 1, 1};
        ramp[1] = '{8'h02, 16'hFFFB,  6, 2, 2, 2};
        ramp[2] = '{8'h04, 16'hFFEF, 10, 3, 3, 3};
        ramp[3] = '{8'h08, 16'hFFBF, 16, 3, 4, 4};
        ramp[4] = '{8'h10, 16'hFEFF, 22, 3, 5, 5};
        ramp[5] = '{8'h20, 16'hFBFF, 28, 4, 6, 6};

        for (int k = 0; k < 6; k++) mix[k] = '{8'hFF, 16'h2AAA, 14 * (k + 1), 1, 0, 7};
        mix[6] = '{8'h7F, 16'hC6AA,  95, 1, 0, 7};
        mix[7] = '{8'h01, 16'hFFFD,  96, 2, 1, 7};
        mix[8] = '{8'h03, 16'hFFF5, 100, 3, 3, 7};
        mix[9] = '{8'h0F, 16'hFFDA, 115, 1, 0, 7};

        sat[0] = '{8'h07, 16'h000A, 9930, 1,  0,  7};
        sat[1] = '{8'h01, 16'h0002, 9932, 2,  1,  7};
        sat[2] = '{8'h03, 16'h000A, 9940, 3,  3,  7};
        sat[3] = '{8'h07, 16'h002A, 9958, 4,  6,  7};
        sat[4] = '{8'h0F, 16'h00AA, 9990, 5, 10, 10};
        sat[5] = '{8'h01, 16'h0002, 9999, 5, 11, 11};
        sat[6] = '{8'h01, 16'h0001, 9999, 5, 12, 12};

        // reset with all lanes firing
        rst_n = 1'b0; freeze = 1'b0; ev_valid = 8'hFF; ev_grade = 16'hAAAA;
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1; ev_valid = 8'h00; ev_grade = 16'h0000;
        check_now("reset", 0, 1, 0, 0, 0);
        idle(2);
        check_now("reset_hold", 0, 1, 0, 0, 0);

        // single PERFECT every cycle
        for (int k = 0; k < 6; k++) send_exp(ramp[k]);
        idle(3);
        check_now("ramp_idle", 28, 4, 6, 6, 0);

        // simultaneous mix of grades
        do_reset();
        for (int k = 0; k < 10; k++) send_exp(mix[k]);
        idle(3);

        // freeze drops an in-flight event
        tick(8'h01, 16'hFFFD, 1'b0);
        tick(8'h00, 16'h0000, 1'b1);
        tick(8'hFF, 16'h2AAA, 1'b1);
        check_now("freeze", 115, 1, 0, 7, 0);
        tick(8'h00, 16'h0000, 1'b1);
        check_now("freeze_hold", 115, 1, 0, 7, 0);
        tick(8'h00, 16'h0000, 1'b0);
        send_exp('{8'h01, 16'hFFFD, 116, 2, 1, 7});
        idle(3);

        // reset right after a hit discards it
        tick(8'h01, 16'h0002, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1; ev_valid = 8'h00; ev_grade = 16'h0000;
        model_reset();
        check_now("midrst", 0, 1, 0, 0, 0);
        idle(2);
        check_now("midrst_hold", 0, 1, 0, 0, 0);

        // reserved grade counts as a miss
        send_exp('{8'h03, 16'h000E, 2, 1, 0, 1});
        send_exp('{8'h01, 16'h0002, 4, 2, 1, 1});
        idle(3);

        // score saturation
        do_reset();
        repeat (709) send(8'hFF, 16'h2AAA);
        for (int k = 0; k < 7; k++) send_exp(sat[k]);
        idle(3);

        // multiplier ceiling and combo saturation
        do_reset();
        repeat (900) send(8'hFF, 16'hAAAA);
        idle(3);
        check_now("ceiling", 9999, 99, 1023, 1023, 0);
        send_exp('{8'hFF, 16'hAAAA, 9999, 99, 1023, 1023});
        idle(3);

        // random traffic against the model
        do_reset();
        for (int k = 0; k < 300; k++) begin
            r = 16'($urandom);
            if ($urandom_range(1) == 0) gg = (r & 16'h5555) | ((~r & 16'h5555) << 1);
            else gg = 16'($urandom);
            if ($urandom_range(3) == 0) idle(1);
            else send(8'($urandom), gg);
        end
        idle(4);
        chk("queue_empty", q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/score_keeper_multi.md
Name: score_keeper_multi

Overview:
- Parametrised successor to the single-lane score keeper. Accepts per-lane judgement events from the lane-judgement logic, up to LANES lanes in the same cycle.
- Maintains four values:
  - a saturating score with graded points (PERFECT/GOOD/MISS),
  - a streak-driven multiplier,
  - the current combo,
  - the best combo of the song.
- Outputs feed the 7-segment and HUD display blocks.
- A freeze input holds all state during pause screens.

Parameters:
- LANES, 8, number of note lanes.
- SCORE_W, 16, score width.
- SCORE_MAX, 9999, score saturation value.
- MULT_W, 7, multiplier width.
- MULT_MAX, 99, multiplier ceiling.
- COMBO_W, 10, combo and max-combo width; saturates at 2^COMBO_W-1.
- PTS_PERFECT, 2, base points for a PERFECT.
- PTS_GOOD, 1, base points for a GOOD.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous active-low reset, sampled on the rising edge of clk.
- freeze  in  1  when high, no state updates; events are dropped.
- ev_valid  in  LANES  per-lane judgement strobe, 1 cycle.
- ev_grade  in  2*LANES  per-lane grade; lane i uses bits [2i+1:2i]. Encoding: 00 MISS, 01 GOOD, 10 PERFECT, 11 reserved (treated as MISS).
- score  out  SCORE_W  current score.
- multiplier  out  MULT_W  current multiplier, range 1..MULT_MAX.
- combo  out  COMBO_W  consecutive non-miss hits.
- max_combo  out  COMBO_W  highest combo since reset.
- update  out  1  pulses for 1 cycle whenever score, multiplier or combo changed.

Behaviour:
- Reset (rst_n low at a clk edge): score=0, multiplier=1, combo=0, max_combo=0, update=0, internal streak=0, stage-1 registers cleared. Reset overrides freeze and any in-flight event.
- Stage 1 (event capture, registered):
  - Counts across valid lanes: n_perf, n_good, n_miss, each log2(LANES)+1 bits wide.
  - base = n_perf*PTS_PERFECT + n_good*PTS_GOOD.
  - any_ev = OR of ev_valid.
  - Lanes with ev_valid=0 are ignored regardless of grade.
- Stage 2 (state update), taken when stage-1 any_ev=1 and freeze=0:
  - hits = n_perf + n_good.
  - Score: add = base*multiplier, using the multiplier held before this update. score_next = min(score+add, SCORE_MAX). Compute in SCORE_W+MULT_W+4 bits so there is no wrap before the compare.
  - Miss present (n_miss>0): hits in the same cycle still score first. Then multiplier=1, streak=0, combo=0. max_combo is updated using combo+hits before the clear.
  - No miss:
    - combo += hits, saturating.
    - max_combo = max(max_combo, new combo).
    - Multiplier step: s = streak+hits. If s >= multiplier and multiplier < MULT_MAX, then multiplier += 1 and streak = s - multiplier(old). Otherwise streak = s, saturating at MULT_MAX.
    - At most one multiplier step per cycle.
    - At MULT_MAX the multiplier holds and streak keeps counting, saturated.
  - update=1 in the cycle after any stage-2 update, else 0.
- Latency: an event at edge N appears in the outputs after edge N+2, with update high during that same cycle.
- Freeze:
  - Stage-1 capture is suppressed while freeze is high.
  - An event already held in stage 1 when freeze rises is discarded.
  - Outputs hold their values; update=0.
- Back-to-back events every cycle are fully supported (throughput 1 per cycle).
- Fixed points: score at SCORE_MAX stays at SCORE_MAX; combo at its maximum stays at its maximum.

Decomposition:
- Shared package score_pkg holds:
  - grade encodings GRADE_MISS, GRADE_GOOD, GRADE_PERFECT,
  - default SCORE_MAX, MULT_MAX, PTS_* constants,
  - the grade_t typedef (2 bits).
- One sub-module: lane_grade_counter. It is combinational popcount of valid lanes per grade, plus the base-points sum, parametrised by LANES. It is instantiated inside the stage-1 logic.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with ev_valid=8'hFF → all outputs 0 except multiplier=1; update=0.
- Ramp: single-lane PERFECT every cycle from reset:
  - score sequence 2,6,10,16,22,28,…
  - multiplier goes 1→2 after the 1st hit and 2→3 after the 3rd.
  - combo increments by 1 per hit.
  - each output appears 2 cycles after its event.
- Simultaneous mix: multiplier=3, score=100, one cycle with 2 PERFECT + 1 GOOD + 1 MISS:
  - score=115, multiplier=1, combo=0,
  - max_combo = max(previous, previous combo + 3).
- Saturation: score=9990, multiplier=5, 1 PERFECT → score=9999; a following GOOD keeps it at 9999. With multiplier at 99, further hits leave it at 99.
- Freeze: event on cycle N, freeze high on N+1 → event dropped, outputs unchanged, update=0. Release freeze, send a GOOD → normal 2-cycle update.
- Mid-operation reset: rst_n low on the cycle after a hit event → the stage-1 event is discarded and outputs are at reset values on the next cycle. Reserved grade 11 is treated as a MISS.
